sha256_block_sequencer: RTL

// Message-level controller for the 64-round SHA-256 compression core. Accepts padded 512-bit blocks,

---
 rtl/sha256_block_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer
//
// Message-level controller for an external 64-round SHA-256 compression core.
// It accepts padded 512-bit blocks and expands each one into the 64-word
// message schedule, one word per cycle. It then starts the core and waits for
// its done pulse, with a timeout. The core's working variables are added into
// the chaining value. After the last block of a message, the new chaining
// value is presented as the digest.
//
// Ports
//   clk           clock
//   reset         synchronous, active-high reset
//   blk_valid     padded block offered
//   blk_ready     sequencer can accept a block (IDLE only)
//   blk_data      512-bit block, W[0] in [511:480] ... W[15] in [31:0]
//   blk_first     block starts a new message (chaining value restarts at IV)
//   blk_last      block ends the message (digest produced after it)
//   digest_valid  digest available
//   digest_ready  consumer accepts digest
//   digest        H0 in [255:224] ... H7 in [31:0]
//   busy          sequencer not idle
//   err           sticky: core timeout, or continuation block with no open message
//   core_reset    high holds the core loaded/frozen; low only while RUN
//   core_h_in     chaining value to the core, word 0 in MSBs
//   core_w        64-word schedule, W[0] in MSBs
//   core_done     core completion pulse (only honoured in RUN)
//   core_h_out    core working variables a..h, a in MSBs
module sha256_block_sequencer #(
  parameter logic [255:0] IV          =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19,
  parameter int unsigned  TIMEOUT_CYC = 80
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  logic [511:0]  blk_data,
  input  logic          blk_first,
  input  logic          blk_last,
  output logic          digest_valid,
  input  logic          digest_ready,
  output logic [255:0]  digest,
  output logic          busy,
  output logic          err,
  output logic          core_reset,
  output logic [255:0]  core_h_in,
  output logic [2047:0] core_w,
  input  logic          core_done,
  input  logic [255:0]  core_h_out
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    StIdle,
    StExpand,
    StStart,
    StRun,
    StAccum,
    StOut
  } state_e;

  state_e          state;
  state_e          state_nxt;
  logic [31:0]     w [64];
  logic [5:0]      cnt;
  logic [TmoW-1:0] tmo;
  logic [255:0]    chain;
  logic [255:0]    sampled;
  logic [255:0]    chain_sum;
  logic            last;
  logic            msg_open;
  logic            accept;
  logic [31:0]     w_new;

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  assign accept    = blk_valid & blk_ready;
  assign core_h_in = chain;

  // Schedule word t = cnt; cnt only ranges 16..63 while expanding, so the
  // 6-bit subtractions never wrap in use.
  always_comb begin
    w_new = sig1(w[cnt - 6'd2]) + w[cnt - 6'd7] + sig0(w[cnt - 6'd15]) + w[cnt - 6'd16];
  end

  always_comb begin
    core_w = '0;
    for (int i = 0; i < 64; i++) begin
      core_w[2047 - 32*i -: 32] = w[i];
    end
  end

  // Word-wise add: each 32-bit lane wraps independently, no carry between lanes.
  always_comb begin
    chain_sum = '0;
    for (int i = 0; i < 8; i++) begin
      chain_sum[32*i +: 32] = chain[32*i +: 32] + sampled[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      StIdle:   if (accept) state_nxt = StExpand;
      StExpand: if (cnt == 6'd63) state_nxt = StStart;
      StStart:  state_nxt = StRun;
      StRun: begin
        if (core_done) begin
          state_nxt = StAccum;
        end else if (tmo == TmoLast) begin
          state_nxt = StIdle;
        end
      end
      StAccum:  state_nxt = last ? StOut : StIdle;
      StOut:    if (digest_ready) state_nxt = StIdle;
      default:  state_nxt = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= StIdle;
      chain        <= IV;
      for (int i = 0; i < 64; i++) begin
        w[i] <= '0;
      end
      cnt          <= 6'd16;
      tmo          <= '0;
      sampled      <= '0;
      last         <= 1'b0;
      msg_open     <= 1'b0;
      err          <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      blk_ready    <= 1'b0;
      busy         <= 1'b0;
      core_reset   <= 1'b1;
    end else begin
      state        <= state_nxt;
      blk_ready    <= (state_nxt == StIdle);
      busy         <= (state_nxt != StIdle);
      core_reset   <= (state_nxt != StRun);
      digest_valid <= (state_nxt == StOut);

      unique case (state)
        StIdle: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) begin
              w[i] <= blk_data[511 - 32*i -: 32];
            end
            last <= blk_last;
            cnt  <= 6'd16;
            if (blk_first) begin
              // A first block while a message is open simply restarts it.
              chain    <= IV;
              msg_open <= 1'b1;
            end else if (!msg_open) begin
              // Orphan continuation block: flag it and hash it from IV.
              err   <= 1'b1;
              chain <= IV;
            end
          end
        end
        StExpand: begin
          w[cnt] <= w_new;
          cnt    <= cnt + 6'd1;
        end
        StStart: begin
          tmo <= '0;
        end
        StRun: begin
          if (core_done) begin
            sampled <= core_h_out;
          end else begin
            tmo <= tmo + 1'b1;
            if (tmo == TmoLast) begin
              // Core never finished: drop the block and close the message.
              err      <= 1'b1;
              msg_open <= 1'b0;
              chain    <= IV;
            end
          end
        end
        StAccum: begin
          chain <= chain_sum;
          if (last) begin
            digest   <= chain_sum;
            msg_open <= 1'b0;
          end
        end
        StOut: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
